// File: rtl/ysyx_22050612_imem_responder.sv
// ysyx_22050612_imem_responder
//   Instruction-memory responder for the IFU fetch port. It takes one fetch
//   at a time over a valid/ready request channel. After LATENCY cycles it
//   returns the 32-bit word held in an internal array. The array is filled
//   through a dedicated preload port that works independently of the fetch FSM.
//
// Ports
//   clk_i        clock, all state changes on posedge
//   rst_i        synchronous active-high reset (array contents are kept)
//   req_valid_i  fetch request valid
//   req_ready_o  responder idle and able to accept
//   req_addr_i   fetch byte address (pc)
//   rsp_valid_o  response valid, held until rsp_ready_i
//   rsp_ready_i  IFU takes the response
//   rsp_inst_o   fetched instruction word
//   rsp_err_o    access fault (misaligned / out of range)
//   ld_en_i      preload write enable
//   ld_idx_i     preload word index
//   ld_data_i    preload data
//
// Optional feature macro: YSYX_22050612_IMEM_ERRCHK_EN
//   defined   -> misaligned or out-of-range fetches return rsp_err=1, inst=0
//   undefined -> rsp_err tied 0, low address bits ignored, index wraps
module ysyx_22050612_imem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
   parameter int unsigned LATENCY     = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           req_valid_i,
   output logic                           req_ready_o,
   input  logic [63:0]                    req_addr_i,
   output logic                           rsp_valid_o,
   input  logic                           rsp_ready_i,
   output logic [31:0]                    rsp_inst_o,
   output logic                           rsp_err_o,
   input  logic                           ld_en_i,
   input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx_i,
   input  logic [31:0]                    ld_data_i
);

   localparam int unsigned IW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam logic [CW-1:0] CNT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [63:0]   addr_q;
   logic [31:0]   inst_q;
   logic [31:0]   mem_q [DEPTH_WORDS];

   logic          accept;
   logic          enter_resp;
   logic [63:0]   sel_addr;
   logic [IW-1:0] rd_idx;
   logic          fault;

   assign req_ready_o = (state_q == S_IDLE) && !rst_i;
   assign accept      = req_valid_i && req_ready_o;
   assign rsp_valid_o = (state_q == S_RESP);
   assign rsp_inst_o  = inst_q;

   // With LATENCY==1 the array is sampled on the accept edge itself, before
   // addr_q holds the address, so the live request address is used then.
   assign sel_addr = (state_q == S_IDLE) ? req_addr_i : addr_q;

`ifdef YSYX_22050612_IMEM_ERRCHK_EN
   logic [63:0] off;
   logic        err_q;
   assign off    = sel_addr - BASE_ADDR;
   assign rd_idx = off[IW+1:2];
   // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
   assign fault  = (sel_addr[1:0] != 2'b00) || (off >= (64'(DEPTH_WORDS) << 2));
   assign rsp_err_o = err_q;
`else
   assign rd_idx = IW'((sel_addr - BASE_ADDR) >> 2);
   assign fault  = 1'b0;
   assign rsp_err_o = 1'b0;
`endif

   assign enter_resp = ((state_q == S_IDLE) && accept && (LATENCY == 1)) ||
                       ((state_q == S_WAIT) && (cnt_q == '0));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: if (accept) begin
            if (LATENCY == 1) state_d = S_RESP;
            else begin
               state_d = S_WAIT;
               cnt_d   = CNT_INIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) state_d = S_RESP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_RESP: if (rsp_ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         inst_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) addr_q <= req_addr_i;
         // mem_q is read before this edge's preload write lands, so a load
         // to the same index on the sampling edge returns the old word.
         if (enter_resp) inst_q <= fault ? 32'h0000_0000 : mem_q[rd_idx];
      end
   end

`ifdef YSYX_22050612_IMEM_ERRCHK_EN
   always_ff @(posedge clk_i) begin
      if (rst_i)           err_q <= 1'b0;
      else if (enter_resp) err_q <= fault;
   end
`endif

   // Preload port: not reset, honoured in every FSM state.
   always_ff @(posedge clk_i) begin
      if (ld_en_i) mem_q[ld_idx_i] <= ld_data_i;
   end

endmodule
